// File: rtl/uart_tx_fifo1.sv
// UART transmitter with configurable width, parity and stop bits, plus a
// one-entry holding register so back-to-back frames leave no idle gap.
module uart_tx_fifo1 #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic                 i_TX_DV,
  input  logic [DATA_BITS-1:0] i_TX_Data,
  output logic                 o_TX_Ready,
  output logic                 o_TX_Active,
  output logic                 o_TX_Serial,
  output logic                 o_TX_Done
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $fatal(1, "uart_tx_fifo1: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $fatal(1, "uart_tx_fifo1: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $fatal(1, "uart_tx_fifo1: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $fatal(1, "uart_tx_fifo1: STOP_BITS must be 1 or 2");
  end

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic          HAS_PAR   = (PARITY != 0);
  localparam logic          ODD_PAR   = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [3:0]           idx, idx_n;
  logic [DATA_BITS-1:0] shifter;
  logic [DATA_BITS-1:0] hold_data;
  logic                 hold_full;
  logic                 par_bit;
  logic                 done;
  logic                 done_n;
  logic                 load;
  logic                 shift;
  logic                 serial;
  logic                 bit_end;

  assign bit_end = (cnt == LAST_CNT);

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    load    = 1'b0;
    shift   = 1'b0;
    done_n  = 1'b0;
    serial  = 1'b1;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (hold_full) begin
          state_n = S_START;
          load    = 1'b1;
        end
      end
      S_START: begin
        serial = 1'b0;
        if (bit_end) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        serial = shifter[0];
        if (bit_end) begin
          cnt_n = '0;
          shift = 1'b1;
          if (idx == LAST_DATA) begin
            idx_n   = '0;
            state_n = HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      S_PARITY: begin
        serial = par_bit;
        if (bit_end) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_n = '0;
          if (idx == LAST_STOP) begin
            // Frame ends here; a queued word starts its START bit on this same edge.
            idx_n  = '0;
            done_n = 1'b1;
            if (hold_full) begin
              state_n = S_START;
              load    = 1'b1;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        idx_n   = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      done  <= done_n;
    end
  end

  // Parity is taken from the word as it enters the shifter, before shifting starts.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      shifter <= '0;
      par_bit <= 1'b0;
    end else if (load) begin
      shifter <= hold_data;
      par_bit <= (^hold_data) ^ ODD_PAR;
    end else if (shift) begin
      shifter <= shifter >> 1;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (load) begin
      hold_full <= 1'b0;
    end else if (i_TX_DV && !hold_full) begin
      hold_full <= 1'b1;
      hold_data <= i_TX_Data;
    end
  end

  assign o_TX_Ready  = !hold_full;
  assign o_TX_Active = (state != S_IDLE);
  assign o_TX_Serial = serial;
  assign o_TX_Done   = done;

endmodule

// File: tb/tb_uart_tx_fifo1.sv
// Directed bench for uart_tx_fifo1: four instances (8N1, 7E1, 7O1, 8N2),
// all at 4 clocks per bit, checked cycle by cycle against hand-built frames.
module tb_uart_tx_fifo1;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       dv[4];
  logic [8:0] data[4];
  logic       ready[4];
  logic       active[4];
  logic       serial[4];
  logic       done[4];

  int assertions = 0;
  int failures   = 0;

  always #5 clk = ~clk;

  uart_tx_fifo1 #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_8n1 (
    .i_Clock(clk), .i_Rst_L(rst_l), .i_TX_DV(dv[0]), .i_TX_Data(data[0][7:0]),
    .o_TX_Ready(ready[0]), .o_TX_Active(active[0]), .o_TX_Serial(serial[0]), .o_TX_Done(done[0]));

  uart_tx_fifo1 #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) dut_7e1 (
    .i_Clock(clk), .i_Rst_L(rst_l), .i_TX_DV(dv[1]), .i_TX_Data(data[1][6:0]),
    .o_TX_Ready(ready[1]), .o_TX_Active(active[1]), .o_TX_Serial(serial[1]), .o_TX_Done(done[1]));

  uart_tx_fifo1 #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut_7o1 (
    .i_Clock(clk), .i_Rst_L(rst_l), .i_TX_DV(dv[2]), .i_TX_Data(data[2][6:0]),
    .o_TX_Ready(ready[2]), .o_TX_Active(active[2]), .o_TX_Serial(serial[2]), .o_TX_Done(done[2]));

  uart_tx_fifo1 #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut_8n2 (
    .i_Clock(clk), .i_Rst_L(rst_l), .i_TX_DV(dv[3]), .i_TX_Data(data[3][7:0]),
    .o_TX_Ready(ready[3]), .o_TX_Active(active[3]), .o_TX_Serial(serial[3]), .o_TX_Done(done[3]));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertions++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int s, input logic [8:0] word);
    dv[s]   = 1'b1;
    data[s] = word;
    step();
    dv[s]   = 1'b0;
  endtask

  // Expected line level c cycles (1-based) after the edge that enters START.
  function automatic logic exp_bit(input logic [8:0] w, input int nbits, input int has_par,
                                   input logic par_bit, input int c);
    int pos;
    logic [8:0] sh;
    pos = (c - 1) / 4;
    if (pos == 0) return 1'b0;
    if (pos <= nbits) begin
      sh = w >> (pos - 1);
      return sh[0];
    end
    if (has_par != 0 && pos == nbits + 1) return par_bit;
    return 1'b1;
  endfunction

  task automatic run_frame(input int s, input logic [8:0] word, input int nbits, input int has_par,
                           input logic par_bit, input int nstop, input string tag);
    int f;
    f = (1 + nbits + has_par + nstop) * 4;
    applyStimulus(s, word);
    checkOutput({tag, " ready after accept"}, 32'(ready[s]), 32'd0);
    checkOutput({tag, " active after accept"}, 32'(active[s]), 32'd0);
    for (int t = 1; t <= f; t++) begin
      step();
      checkOutput($sformatf("%s serial t=%0d", tag, t), 32'(serial[s]),
                  32'(exp_bit(word, nbits, has_par, par_bit, t)));
      checkOutput($sformatf("%s active t=%0d", tag, t), 32'(active[s]), 32'd1);
      checkOutput($sformatf("%s done t=%0d", tag, t), 32'(done[s]), 32'd0);
      if (t == 1) checkOutput({tag, " ready at start"}, 32'(ready[s]), 32'd1);
    end
    step();
    checkOutput({tag, " done at end"}, 32'(done[s]), 32'd1);
    checkOutput({tag, " active at end"}, 32'(active[s]), 32'd0);
    checkOutput({tag, " serial at end"}, 32'(serial[s]), 32'd1);
    step();
    checkOutput({tag, " done one cycle"}, 32'(done[s]), 32'd0);
  endtask

  initial begin
    logic [8:0] w;
    for (int i = 0; i < 4; i++) begin
      dv[i]   = 1'b0;
      data[i] = '0;
    end

    // Reset values, then 20 idle cycles.
    rst_l = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rst serial[%0d]", i), 32'(serial[i]), 32'd1);
      checkOutput($sformatf("rst ready[%0d]", i), 32'(ready[i]), 32'd1);
      checkOutput($sformatf("rst active[%0d]", i), 32'(active[i]), 32'd0);
      checkOutput($sformatf("rst done[%0d]", i), 32'(done[i]), 32'd0);
    end
    rst_l = 1'b1;
    for (int t = 0; t < 20; t++) begin
      step();
      checkOutput($sformatf("idle serial t=%0d", t), 32'(serial[0]), 32'd1);
      checkOutput($sformatf("idle ready t=%0d", t), 32'(ready[0]), 32'd1);
      checkOutput($sformatf("idle active t=%0d", t), 32'(active[0]), 32'd0);
      checkOutput($sformatf("idle done t=%0d", t), 32'(done[0]), 32'd0);
    end

    run_frame(0, 9'h0A5, 8, 0, 1'b0, 1, "8n1 A5");
    run_frame(1, 9'h013, 7, 1, 1'b1, 1, "7e1 13");
    run_frame(2, 9'h013, 7, 1, 1'b0, 1, "7o1 13");
    run_frame(3, 9'h0E7, 8, 0, 1'b0, 2, "8n2 E7");

    // Back-to-back 0x55 then 0x0F; the second word is offered during DATA.
    applyStimulus(0, 9'h055);
    for (int t = 1; t <= 81; t++) begin
      if (t == 11) begin
        dv[0]   = 1'b1;
        data[0] = 9'h00F;
      end
      step();
      if (t == 11) dv[0] = 1'b0;
      w = (t <= 40) ? 9'h055 : 9'h00F;
      checkOutput($sformatf("b2b serial t=%0d", t), 32'(serial[0]),
                  (t <= 80) ? 32'(exp_bit(w, 8, 0, 1'b0, ((t - 1) % 40) + 1)) : 32'd1);
      checkOutput($sformatf("b2b active t=%0d", t), 32'(active[0]), (t <= 80) ? 32'd1 : 32'd0);
      checkOutput($sformatf("b2b done t=%0d", t), 32'(done[0]), (t == 41 || t == 81) ? 32'd1 : 32'd0);
      checkOutput($sformatf("b2b ready t=%0d", t), 32'(ready[0]), (t < 11 || t >= 41) ? 32'd1 : 32'd0);
    end
    step();

    // Two stop bits, three queued words; data wiggles while not ready.
    applyStimulus(3, 9'h03C);
    checkOutput("8n2 q ready after accept", 32'(ready[3]), 32'd0);
    for (int t = 1; t <= 133; t++) begin
      if (t == 2) begin
        dv[3]   = 1'b1;
        data[3] = 9'h081;
      end else if (t >= 3 && t <= 45) begin
        data[3] = 9'(t);
      end else if (t == 46) begin
        data[3] = 9'h0C3;
      end
      step();
      if (t == 46) dv[3] = 1'b0;
      case ((t - 1) / 44)
        0:       w = 9'h03C;
        1:       w = 9'h081;
        default: w = 9'h0C3;
      endcase
      checkOutput($sformatf("8n2 q serial t=%0d", t), 32'(serial[3]),
                  (t <= 132) ? 32'(exp_bit(w, 8, 0, 1'b0, ((t - 1) % 44) + 1)) : 32'd1);
      checkOutput($sformatf("8n2 q active t=%0d", t), 32'(active[3]), (t <= 132) ? 32'd1 : 32'd0);
      checkOutput($sformatf("8n2 q done t=%0d", t), 32'(done[3]),
                  (t == 45 || t == 89 || t == 133) ? 32'd1 : 32'd0);
      checkOutput($sformatf("8n2 q ready t=%0d", t), 32'(ready[3]),
                  (t == 1 || t == 45 || t >= 89) ? 32'd1 : 32'd0);
    end
    step();

    // Reset during data bit 3 with a second word queued.
    applyStimulus(0, 9'h0F0);
    for (int t = 1; t <= 18; t++) begin
      if (t == 3) begin
        dv[0]   = 1'b1;
        data[0] = 9'h00A;
      end
      step();
      if (t == 3) dv[0] = 1'b0;
      checkOutput($sformatf("abort serial t=%0d", t), 32'(serial[0]),
                  32'(exp_bit(9'h0F0, 8, 0, 1'b0, t)));
    end
    checkOutput("abort ready queued", 32'(ready[0]), 32'd0);
    rst_l = 1'b0;
    step();
    checkOutput("abort serial on reset", 32'(serial[0]), 32'd1);
    checkOutput("abort ready on reset", 32'(ready[0]), 32'd1);
    checkOutput("abort active on reset", 32'(active[0]), 32'd0);
    checkOutput("abort done on reset", 32'(done[0]), 32'd0);
    rst_l = 1'b1;
    for (int t = 0; t < 60; t++) begin
      step();
      checkOutput($sformatf("post abort serial t=%0d", t), 32'(serial[0]), 32'd1);
      checkOutput($sformatf("post abort active t=%0d", t), 32'(active[0]), 32'd0);
      checkOutput($sformatf("post abort done t=%0d", t), 32'(done[0]), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
